// File: rtl/stoch_im2col_scheduler.sv
// stoch_im2col_scheduler
// Captures one signed stochastic (plus/minus) bitstream image, then streams its
// im2col windows one per cycle under valid/ready, walking output positions row-major.
//
// state  | meaning
// IDLE   | ready to capture an image; no window on the output
// STREAM | presenting window idx_q; advances on each accepted window
module stoch_im2col_scheduler #(
  parameter int IM_HEIGHT = 12,
  parameter int IM_WIDTH  = 12,
  parameter int CHANNELS  = 8,
  parameter int KERNEL_H  = 3,
  parameter int KERNEL_W  = 3,
  parameter int PAD_H     = 2,
  parameter int PAD_W     = 2,
  parameter int STRIDE_H  = 1,
  parameter int STRIDE_W  = 1,
  localparam int OUT_H     = (IM_HEIGHT + 2 * PAD_H - KERNEL_H) / STRIDE_H + 1,
  localparam int OUT_W     = (IM_WIDTH + 2 * PAD_W - KERNEL_W) / STRIDE_W + 1,
  localparam int N_WIN     = OUT_H * OUT_W,
  localparam int COL_WIDTH = KERNEL_H * KERNEL_W * CHANNELS,
  localparam int IDX_W     = (N_WIN > 1) ? $clog2(N_WIN) : 1
) (
  input  logic                                          CLK,
  input  logic                                          nRST,
  input  logic                                          flush,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0] im_p,
  input  logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0] im_m,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [COL_WIDTH-1:0]                          out_col_p,
  output logic [COL_WIDTH-1:0]                          out_col_m,
  output logic [IDX_W-1:0]                              out_idx,
  output logic                                          out_last,
  output logic                                          frame_done
);

  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int OCW_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t state_q, state_d;

  logic [ROW_W-1:0] orow_q;
  logic [OCW_W-1:0] ocol_q;
  logic [IDX_W-1:0] idx_q;

  // Image kept channel-major so each (channel, row) is a plain column vector.
  logic [CHANNELS-1:0][IM_HEIGHT-1:0][IM_WIDTH-1:0] img_p_q, img_m_q;
  logic [CHANNELS-1:0][IM_HEIGHT-1:0][IM_WIDTH-1:0] im_p_t, im_m_t;

  logic capture, accept, last_win, row_end;

  for (genvar r = 0; r < IM_HEIGHT; r++) begin : g_tr_r
    for (genvar c = 0; c < IM_WIDTH; c++) begin : g_tr_c
      for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_tr_ch
        assign im_p_t[ch][r][c] = im_p[r][c][ch];
        assign im_m_t[ch][r][c] = im_m[r][c][ch];
      end
    end
  end

  assign capture  = in_valid & in_ready & ~flush;
  assign accept   = out_valid & out_ready;
  assign last_win = (idx_q == IDX_W'(N_WIN - 1));
  assign row_end  = (ocol_q == OCW_W'(OUT_W - 1));

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; flush overrides any capture or frame end.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready && last_win) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Output-position walk: column-fastest, restarted on capture, flush or frame end.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      orow_q <= '0;
      ocol_q <= '0;
      idx_q  <= '0;
    end else if (flush || capture) begin
      orow_q <= '0;
      ocol_q <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      if (last_win) begin
        orow_q <= '0;
        ocol_q <= '0;
        idx_q  <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
        if (row_end) begin
          ocol_q <= '0;
          orow_q <= orow_q + 1'b1;
        end else begin
          ocol_q <= ocol_q + 1'b1;
        end
      end
    end
  end

  // Image registers load only on the capture handshake.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      img_p_q <= '0;
      img_m_q <= '0;
    end else if (capture) begin
      img_p_q <= im_p_t;
      img_m_q <= im_m_t;
    end
  end

  // Frame-done pulse follows acceptance of the last window unless flushed.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) frame_done <= 1'b0;
    else       frame_done <= accept & last_win & ~flush;
  end

  // One-hot row/column hits per kernel tap; taps landing in padding hit nothing.
  logic [KERNEL_H-1:0][IM_HEIGHT-1:0] row_hit;
  logic [KERNEL_W-1:0][IM_WIDTH-1:0]  col_hit;

  for (genvar kr = 0; kr < KERNEL_H; kr++) begin : g_rh
    for (genvar i = 0; i < IM_HEIGHT; i++) begin : g_rh_i
      assign row_hit[kr][i] = (int'(orow_q) * STRIDE_H + kr == i + PAD_H);
    end
  end

  for (genvar kc = 0; kc < KERNEL_W; kc++) begin : g_ch
    for (genvar j = 0; j < IM_WIDTH; j++) begin : g_ch_j
      assign col_hit[kc][j] = (int'(ocol_q) * STRIDE_W + kc == j + PAD_W);
    end
  end

  logic [COL_WIDTH-1:0] win_p, win_m;

  for (genvar kr = 0; kr < KERNEL_H; kr++) begin : g_wr
    for (genvar kc = 0; kc < KERNEL_W; kc++) begin : g_wc
      for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_wch
        logic [IM_HEIGHT-1:0] hit_p, hit_m;
        for (genvar i = 0; i < IM_HEIGHT; i++) begin : g_row
          assign hit_p[i] = row_hit[kr][i] & (|(col_hit[kc] & img_p_q[ch][i]));
          assign hit_m[i] = row_hit[kr][i] & (|(col_hit[kc] & img_m_q[ch][i]));
        end
        assign win_p[kc + kr * KERNEL_W + ch * KERNEL_H * KERNEL_W] = |hit_p;
        assign win_m[kc + kr * KERNEL_W + ch * KERNEL_H * KERNEL_W] = |hit_m;
      end
    end
  end

  assign out_col_p = out_valid ? win_p : '0;
  assign out_col_m = out_valid ? win_m : '0;
  assign out_idx   = idx_q;
  assign out_last  = out_valid & last_win;

endmodule

// File: tb/tb_stoch_im2col_scheduler.sv
// Bench for stoch_im2col_scheduler: small 2x2 instance for directed scenarios,
// default-parameter instance for reset and randomized frames against an im2col model.
module tb_stoch_im2col_scheduler;
  localparam int SH = 2, SW = 2, SC = 1, SK = 3, SP = 1;
  localparam int S_OUT = 2, S_NWIN = 4, S_COLW = 9;
  localparam int DH = 12, DW = 12, DC = 8, DK = 3, DP = 2;
  localparam int D_OUT = 14, D_NWIN = 196, D_COLW = 72;

  logic CLK = 1'b0;
  logic nRST = 1'b1;
  always #5 CLK = ~CLK;

  logic s_flush = 0, s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0, s_out_last, s_frame_done;
  logic [SH-1:0][SW-1:0][SC-1:0] s_im_p = '0, s_im_m = '0;
  logic [S_COLW-1:0] s_col_p, s_col_m;
  logic [1:0] s_idx;

  logic d_flush = 0, d_in_valid = 0, d_in_ready, d_out_valid, d_out_ready = 0, d_out_last, d_frame_done;
  logic [DH-1:0][DW-1:0][DC-1:0] d_im_p = '0, d_im_m = '0;
  logic [D_COLW-1:0] d_col_p, d_col_m;
  logic [7:0] d_idx;

  int n_checks = 0;
  int n_fail = 0;

  stoch_im2col_scheduler #(
    .IM_HEIGHT(SH), .IM_WIDTH(SW), .CHANNELS(SC), .KERNEL_H(SK), .KERNEL_W(SK),
    .PAD_H(SP), .PAD_W(SP), .STRIDE_H(1), .STRIDE_W(1)
  ) dut_s (
    .CLK(CLK), .nRST(nRST), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .im_p(s_im_p), .im_m(s_im_m), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_col_p(s_col_p), .out_col_m(s_col_m), .out_idx(s_idx), .out_last(s_out_last),
    .frame_done(s_frame_done)
  );

  stoch_im2col_scheduler dut_d (
    .CLK(CLK), .nRST(nRST), .flush(d_flush), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .im_p(d_im_p), .im_m(d_im_m), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_col_p(d_col_p), .out_col_m(d_col_m), .out_idx(d_idx), .out_last(d_out_last),
    .frame_done(d_frame_done)
  );

  // Golden im2col: window w -> (orow, ocol), tap (kr, kc, ch) reads the padded image.
  function automatic logic [S_COLW-1:0] ref_s(input logic [SH-1:0][SW-1:0][SC-1:0] img, input int w);
    int orow, ocol, r, c;
    ref_s = '0;
    orow = w / S_OUT;
    ocol = w % S_OUT;
    for (int kr = 0; kr < SK; kr++)
      for (int kc = 0; kc < SK; kc++)
        for (int ch = 0; ch < SC; ch++) begin
          r = orow - SP + kr;
          c = ocol - SP + kc;
          if (r >= 0 && r < SH && c >= 0 && c < SW) ref_s[kc + kr * SK + ch * SK * SK] = img[r][c][ch];
        end
  endfunction

  function automatic logic [D_COLW-1:0] ref_d(input logic [DH-1:0][DW-1:0][DC-1:0] img, input int w);
    int orow, ocol, r, c;
    ref_d = '0;
    orow = w / D_OUT;
    ocol = w % D_OUT;
    for (int kr = 0; kr < DK; kr++)
      for (int kc = 0; kc < DK; kc++)
        for (int ch = 0; ch < DC; ch++) begin
          r = orow - DP + kr;
          c = ocol - DP + kc;
          if (r >= 0 && r < DH && c >= 0 && c < DW) ref_d[kc + kr * DK + ch * DK * DK] = img[r][c][ch];
        end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_capture_s(input logic [SH-1:0][SW-1:0][SC-1:0] p, input logic [SH-1:0][SW-1:0][SC-1:0] m);
    s_im_p = p;
    s_im_m = m;
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 nRST = 1'b0;
    #2;
    n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", s_in_ready); end
    n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", s_out_valid); end
    n_checks++; if (s_out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", s_out_last); end
    n_checks++; if (s_frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", s_frame_done); end
    n_checks++; if (s_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", s_idx); end
    n_checks++; if (s_col_p !== '0 || s_col_m !== '0) begin n_fail++; $display("FAIL reset_cols: got p=%h m=%h want 0", s_col_p, s_col_m); end
    n_checks++; if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_default_hs: got rdy=%b vld=%b want 1/0", d_in_ready, d_out_valid); end
    @(negedge CLK);
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_basic_stream();
    logic [SH-1:0][SW-1:0][SC-1:0] p;
    logic [S_COLW-1:0] tab [4];
    tab[0] = 9'h110; tab[1] = 9'h088; tab[2] = 9'h022; tab[3] = 9'h011;
    p = '0; p[0][0][0] = 1'b1; p[1][1][0] = 1'b1;
    s_out_ready = 1'b1;
    n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b want 1", s_in_ready); end
    drive_capture_s(p, '0);
    for (int w = 0; w < S_NWIN; w++) begin
      n_checks++; if (s_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid w%0d: got %b want 1", w, s_out_valid); end
      n_checks++; if (s_idx !== 2'(w)) begin n_fail++; $display("FAIL basic_idx: got %0d want %0d", s_idx, w); end
      n_checks++; if (s_col_p !== tab[w]) begin n_fail++; $display("FAIL basic_col_p w%0d: got %h want %h", w, s_col_p, tab[w]); end
      n_checks++; if (s_col_p !== ref_s(p, w)) begin n_fail++; $display("FAIL basic_model w%0d: got %h want %h", w, s_col_p, ref_s(p, w)); end
      n_checks++; if (s_col_m !== '0) begin n_fail++; $display("FAIL basic_col_m w%0d: got %h want 0", w, s_col_m); end
      n_checks++; if (s_out_last !== (w == S_NWIN - 1)) begin n_fail++; $display("FAIL basic_last w%0d: got %b", w, s_out_last); end
      n_checks++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy w%0d: got in_ready %b want 0", w, s_in_ready); end
      tick();
    end
    n_checks++; if (s_frame_done !== 1'b1) begin n_fail++; $display("FAIL basic_frame_done: got %b want 1", s_frame_done); end
    n_checks++; if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got rdy=%b vld=%b want 1/0", s_in_ready, s_out_valid); end
    tick();
    n_checks++; if (s_frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", s_frame_done); end
  endtask

  task automatic test_backpressure();
    logic [SH-1:0][SW-1:0][SC-1:0] p;
    p = '0; p[0][0][0] = 1'b1; p[1][1][0] = 1'b1;
    s_out_ready = 1'b1;
    drive_capture_s(p, '0);
    tick();
    s_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (s_idx !== 2'd1 || s_col_p !== 9'h088) begin n_fail++; $display("FAIL bp_hold c%0d: got idx=%0d p=%h want 1/088", i, s_idx, s_col_p); end
      n_checks++; if (s_out_valid !== 1'b1 || s_out_last !== 1'b0) begin n_fail++; $display("FAIL bp_hold_flags c%0d: got vld=%b last=%b", i, s_out_valid, s_out_last); end
      tick();
    end
    s_out_ready = 1'b1;
    for (int w = 1; w < S_NWIN; w++) begin
      n_checks++; if (s_idx !== 2'(w) || s_col_p !== ref_s(p, w)) begin n_fail++; $display("FAIL bp_resume w%0d: got idx=%0d p=%h want %h", w, s_idx, s_col_p, ref_s(p, w)); end
      tick();
    end
    n_checks++; if (s_frame_done !== 1'b1) begin n_fail++; $display("FAIL bp_frame_done: got %b want 1", s_frame_done); end
    tick();
  endtask

  task automatic test_minus_stream();
    logic [S_COLW-1:0] tab [4];
    tab[0] = 9'h1B0; tab[1] = 9'h0D8; tab[2] = 9'h036; tab[3] = 9'h01B;
    s_out_ready = 1'b1;
    drive_capture_s('0, '1);
    for (int w = 0; w < S_NWIN; w++) begin
      n_checks++; if (s_col_m !== tab[w]) begin n_fail++; $display("FAIL minus_col_m w%0d: got %h want %h", w, s_col_m, tab[w]); end
      n_checks++; if (s_col_p !== '0) begin n_fail++; $display("FAIL minus_col_p w%0d: got %h want 0", w, s_col_p); end
      tick();
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [SH-1:0][SW-1:0][SC-1:0] p1, p2;
    p1 = '0; p1[0][0][0] = 1'b1; p1[1][1][0] = 1'b1;
    p2 = '0; p2[0][1][0] = 1'b1; p2[1][0][0] = 1'b1;
    s_out_ready = 1'b1;
    s_im_p = p1;
    s_im_m = '0;
    s_in_valid = 1'b1;
    tick();
    s_im_p = p2;
    for (int w = 0; w < S_NWIN; w++) begin
      n_checks++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready w%0d: got %b want 0", w, s_in_ready); end
      n_checks++; if (s_col_p !== ref_s(p1, w)) begin n_fail++; $display("FAIL b2b_first w%0d: got %h want %h", w, s_col_p, ref_s(p1, w)); end
      tick();
    end
    n_checks++; if (s_frame_done !== 1'b1 || s_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got done=%b rdy=%b want 1/1", s_frame_done, s_in_ready); end
    tick();
    s_in_valid = 1'b0;
    for (int w = 0; w < S_NWIN; w++) begin
      n_checks++; if (s_out_valid !== 1'b1 || s_idx !== 2'(w) || s_col_p !== ref_s(p2, w)) begin
        n_fail++; $display("FAIL b2b_second w%0d: got vld=%b idx=%0d p=%h want %h", w, s_out_valid, s_idx, s_col_p, ref_s(p2, w));
      end
      tick();
    end
    tick();
  endtask

  task automatic test_flush();
    logic [SH-1:0][SW-1:0][SC-1:0] p1, p3;
    p1 = '0; p1[0][0][0] = 1'b1; p1[1][1][0] = 1'b1;
    p3 = '1;
    s_out_ready = 1'b1;
    drive_capture_s(p1, '0);
    tick();
    tick();
    n_checks++; if (s_idx !== 2'd2) begin n_fail++; $display("FAIL flush_pre_idx: got %0d want 2", s_idx); end
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    n_checks++; if (s_out_valid !== 1'b0 || s_frame_done !== 1'b0) begin n_fail++; $display("FAIL flush_stop: got vld=%b done=%b want 0/0", s_out_valid, s_frame_done); end
    n_checks++; if (s_in_ready !== 1'b1 || s_idx !== 2'd0) begin n_fail++; $display("FAIL flush_idle: got rdy=%b idx=%0d want 1/0", s_in_ready, s_idx); end
    s_im_p = p3;
    s_in_valid = 1'b1;
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_beats_capture: got vld=%b want 0", s_out_valid); end
    tick();
    s_in_valid = 1'b0;
    for (int w = 0; w < S_NWIN; w++) begin
      n_checks++; if (s_out_valid !== 1'b1 || s_idx !== 2'(w) || s_col_p !== ref_s(p3, w)) begin
        n_fail++; $display("FAIL flush_restart w%0d: got vld=%b idx=%0d p=%h want %h", w, s_out_valid, s_idx, s_col_p, ref_s(p3, w));
      end
      if (w == S_NWIN - 1) s_flush = 1'b1;
      tick();
    end
    s_flush = 1'b0;
    n_checks++; if (s_frame_done !== 1'b0 || s_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_last: got done=%b vld=%b want 0/0", s_frame_done, s_out_valid); end
    tick();
    n_checks++; if (s_frame_done !== 1'b0) begin n_fail++; $display("FAIL flush_no_late_done: got %b want 0", s_frame_done); end
  endtask

  task automatic rand_image(output logic [DH-1:0][DW-1:0][DC-1:0] img);
    logic [DH*DW*DC-1:0] flat;
    for (int i = 0; i < DH * DW * DC / 32; i++) flat[i*32 +: 32] = $urandom();
    img = flat;
  endtask

  task automatic test_reset_midframe();
    logic [DH-1:0][DW-1:0][DC-1:0] p, m;
    rand_image(p);
    rand_image(m);
    d_im_p = p;
    d_im_m = m;
    d_out_ready = 1'b1;
    d_in_valid = 1'b1;
    tick();
    d_in_valid = 1'b0;
    for (int w = 0; w < 5; w++) begin
      n_checks++; if (d_idx !== 8'(w) || d_col_p !== ref_d(p, w) || d_col_m !== ref_d(m, w)) begin
        n_fail++; $display("FAIL rst_pre w%0d: got idx=%0d p=%h m=%h", w, d_idx, d_col_p, d_col_m);
      end
      tick();
    end
    #2 nRST = 1'b0;
    #1;
    n_checks++; if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_hs: got vld=%b rdy=%b want 0/1", d_out_valid, d_in_ready); end
    n_checks++; if (d_idx !== 8'd0 || d_out_last !== 1'b0 || d_frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_async_ctr: got idx=%0d last=%b done=%b", d_idx, d_out_last, d_frame_done); end
    n_checks++; if (d_col_p !== '0 || d_col_m !== '0) begin n_fail++; $display("FAIL rst_async_cols: got p=%h m=%h want 0", d_col_p, d_col_m); end
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    n_checks++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_frame_lost: got vld=%b want 0", d_out_valid); end
  endtask

  task automatic test_random_frames();
    logic [DH-1:0][DW-1:0][DC-1:0] p, m;
    int exp_w, cyc;
    for (int f = 0; f < 3; f++) begin
      rand_image(p);
      rand_image(m);
      n_checks++; if (d_in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_in_ready f%0d: got %b want 1", f, d_in_ready); end
      d_im_p = p;
      d_im_m = m;
      d_in_valid = 1'b1;
      tick();
      d_in_valid = 1'b0;
      d_im_p = '0;
      exp_w = 0;
      cyc = 0;
      while (exp_w < D_NWIN && cyc < 3000) begin
        d_out_ready = ($urandom_range(0, 3) != 0);
        n_checks++; if (d_out_valid !== 1'b1 || d_idx !== 8'(exp_w)) begin n_fail++; $display("FAIL rnd_idx f%0d: got vld=%b idx=%0d want 1/%0d", f, d_out_valid, d_idx, exp_w); end
        n_checks++; if (d_col_p !== ref_d(p, exp_w)) begin n_fail++; $display("FAIL rnd_col_p f%0d w%0d: got %h want %h", f, exp_w, d_col_p, ref_d(p, exp_w)); end
        n_checks++; if (d_col_m !== ref_d(m, exp_w)) begin n_fail++; $display("FAIL rnd_col_m f%0d w%0d: got %h want %h", f, exp_w, d_col_m, ref_d(m, exp_w)); end
        n_checks++; if (d_out_last !== (exp_w == D_NWIN - 1)) begin n_fail++; $display("FAIL rnd_last f%0d w%0d: got %b", f, exp_w, d_out_last); end
        if (d_out_ready) exp_w++;
        tick();
        cyc++;
      end
      n_checks++; if (exp_w != D_NWIN) begin n_fail++; $display("FAIL rnd_timeout f%0d: got %0d windows want %0d", f, exp_w, D_NWIN); end
      n_checks++; if (d_frame_done !== 1'b1) begin n_fail++; $display("FAIL rnd_frame_done f%0d: got %b want 1", f, d_frame_done); end
      d_out_ready = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_minus_stream();
    test_back_to_back();
    test_flush();
    test_reset_midframe();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d checks done", n_checks);
    $fatal(1);
  end
endmodule
